// File: rtl/capture_ctrl.sv
// Camera frame capture controller: arms on inicio, aligns to a full frame on vsync, and writes
// up to H_PIX x V_LINES pixels. Defining CAPTURE_CONTINUOUS_EN re-arms automatically after each frame.
module capture_ctrl #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 96
) (
  input  logic        pclk,
  input  logic        in_reset,
  input  logic        inicio,
  input  logic        vsync,
  input  logic        href,
  input  logic        px_valid,
  output logic [14:0] mem_addr,
  output logic        mem_wr,
  output logic [7:0]  pix_cnt,
  output logic [6:0]  line_cnt,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_SYNC    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [15:0] FRAME_PIX = 16'(H_PIX * V_LINES);
  localparam logic [7:0]  H_MAX     = 8'(H_PIX);
  localparam logic [6:0]  V_LAST    = 7'(V_LINES - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic        href_d_r;
  logic [15:0] addr_next_s;
  logic        in_cap_s;
  logic        frame_full_s;
  logic        line_end_s;
  logic        accept_s;
  logic        abort_s;
  logic        last_line_s;
  logic        cap_entry_s;

  // mem_addr advances on the cycle its write is presented, so the next free address
  // already accounts for a write still on the bus.
  assign addr_next_s  = {1'b0, mem_addr} + {15'd0, mem_wr};
  assign in_cap_s     = (state_r == ST_CAPTURE);
  assign frame_full_s = (addr_next_s >= FRAME_PIX);
  assign line_end_s   = in_cap_s & href_d_r & ~href & (pix_cnt != 8'd0);
  assign abort_s      = in_cap_s & ~frame_full_s & vsync;
  assign accept_s     = in_cap_s & ~frame_full_s & ~vsync & href & px_valid & (pix_cnt < H_MAX);
  assign last_line_s  = line_end_s & (line_cnt == V_LAST);
  assign cap_entry_s  = (state_r == ST_SYNC) & ~vsync;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (inicio) state_s = ST_ARM;
        else        state_s = ST_IDLE;
      end
      ST_ARM: begin
        if (vsync) state_s = ST_SYNC;
        else       state_s = ST_ARM;
      end
      ST_SYNC: begin
        if (!vsync) state_s = ST_CAPTURE;
        else        state_s = ST_SYNC;
      end
      ST_CAPTURE: begin
        if (frame_full_s || abort_s || last_line_s) state_s = ST_DONE;
        else                                        state_s = ST_CAPTURE;
      end
      ST_DONE: begin
`ifdef CAPTURE_CONTINUOUS_EN
        state_s = ST_ARM;
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge pclk) begin
    if (in_reset) begin
      state_r   <= ST_IDLE;
      href_d_r  <= 1'b0;
      mem_addr  <= 15'd0;
      mem_wr    <= 1'b0;
      pix_cnt   <= 8'd0;
      line_cnt  <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_r  <= state_s;
      href_d_r <= href;
      mem_wr   <= accept_s;
      busy     <= (state_s == ST_ARM) || (state_s == ST_SYNC) || (state_s == ST_CAPTURE);
      done     <= (state_s == ST_DONE);

      if ((state_r == ST_IDLE) && (state_s == ST_ARM)) frame_err <= 1'b0;
      else if (abort_s)                                frame_err <= 1'b1;
      else                                             frame_err <= frame_err;

      if (cap_entry_s) begin
        mem_addr <= 15'd0;
        pix_cnt  <= 8'd0;
        line_cnt <= 7'd0;
      end else begin
        mem_addr <= addr_next_s[14:0];
        // Short lines are not padded: only the line counter moves at a line end.
        if (accept_s) begin
          pix_cnt  <= pix_cnt + 8'd1;
          line_cnt <= line_cnt;
        end else if (line_end_s) begin
          pix_cnt  <= 8'd0;
          line_cnt <= line_cnt + 7'd1;
        end else begin
          pix_cnt  <= pix_cnt;
          line_cnt <= line_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: a frame-level model predicts every write address and
// done/frame_err outcome; a negedge monitor checks each write against that prediction.
module tb_capture_ctrl;

  logic        pclk = 1'b0;
  logic        in_reset, inicio, vsync, href, px_valid;
  logic [14:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  pix_cnt;
  logic [6:0]  line_cnt;
  logic        busy, done, frame_err;

  capture_ctrl #(.H_PIX(160), .V_LINES(96)) dut (
    .pclk(pclk), .in_reset(in_reset), .inicio(inicio), .vsync(vsync), .href(href),
    .px_valid(px_valid), .mem_addr(mem_addr), .mem_wr(mem_wr), .pix_cnt(pix_cnt),
    .line_cnt(line_cnt), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int dut_done = 0;
  logic done_prev = 1'b0;

  // Frame-level model: capture mode flags plus expected address/pixel/line progress.
  bit mdl_idle, mdl_armed, mdl_active, mdl_err;
  int mdl_addr, mdl_pix, mdl_line, mdl_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic mdl_finish();
    mdl_done++;
    mdl_active = 1'b0;
`ifdef CAPTURE_CONTINUOUS_EN
    mdl_armed = 1'b1;
`else
    mdl_idle = 1'b1;
`endif
  endtask

  task automatic do_reset();
    in_reset = 1'b1; inicio = 1'b0; vsync = 1'b0; href = 1'b0; px_valid = 1'b0;
    tick();
    in_reset = 1'b0;
    mdl_idle = 1'b1; mdl_armed = 1'b0; mdl_active = 1'b0; mdl_err = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic do_inicio();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    if (mdl_idle) begin
      mdl_idle = 1'b0; mdl_armed = 1'b1; mdl_err = 1'b0;
    end
    tick();
  endtask

  task automatic do_vsync();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    if (mdl_active) begin
      mdl_err = 1'b1;
      mdl_finish();
    end else if (mdl_armed) begin
      mdl_armed = 1'b0; mdl_active = 1'b1;
      mdl_addr = 0; mdl_pix = 0; mdl_line = 0;
    end
    tick();
    tick();
  endtask

  task automatic send_px(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      px_valid = 1'b1;
      if (mdl_active && mdl_pix < 160 && mdl_addr < 15360) begin
        exp_q.push_back(mdl_addr);
        mdl_addr++;
        mdl_pix++;
        if (mdl_addr == 15360) mdl_finish();
      end
      tick();
      px_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic end_line();
    href = 1'b0;
    tick();
    tick();
    if (mdl_active && mdl_pix > 0) begin
      mdl_pix = 0;
      mdl_line++;
      if (mdl_line == 96) mdl_finish();
    end
  endtask

  task automatic send_line(input int n, input int gap);
    href = 1'b1;
    tick();
    send_px(n, gap);
    end_line();
  endtask

  // Every presented write must be the next address the model expects; done is a single cycle.
  always @(negedge pclk) begin
    if (mem_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: write at addr %0d, expected no write", mem_addr);
      end else begin
        check("wr_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
      end
    end
    if (done === 1'b1) dut_done++;
    check("done_one_cycle", {31'd0, done_prev & done}, 32'd0);
    done_prev <= done;
  end

  initial begin
    in_reset = 1'b1; inicio = 1'b0; vsync = 1'b0; href = 1'b0; px_valid = 1'b0;
    mdl_done = 0;
    do_reset();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_pix", 32'(pix_cnt), 32'd0);
    check("rst_line", 32'(line_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);

    // Full frame: 96 x 160 pixels
    do_inicio();
    check("arm_busy", 32'(busy), 32'd1);
    do_vsync();
    for (int l = 0; l < 96; l++) send_line(160, 1);
    check("full_done_model", 32'(dut_done), 32'(mdl_done));
    check("full_done_lit", 32'(dut_done), 32'd1);
    check("full_err", 32'(frame_err), 32'd0);
    check("full_addr", 32'(mem_addr), 32'd15360);
    check("full_busy", 32'(busy), 32'(mdl_armed));
    check("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Second frame without a new inicio
    do_vsync();
    send_line(160, 1);
    send_line(160, 1);
`ifndef CAPTURE_CONTINUOUS_EN
    check("no_rearm_addr", 32'(mem_addr), 32'd15360);
`endif
    check("rearm_q_empty", 32'(exp_q.size()), 32'd0);
    check("rearm_done", 32'(dut_done), 32'(mdl_done));
    do_reset();

    // Overrun line, then a short unpadded line, then vsync abort
    do_inicio();
    do_vsync();
    href = 1'b1;
    tick();
    send_px(170, 0);
    check("ovr_pix_hold", 32'(pix_cnt), 32'd160);
    check("ovr_addr", 32'(mem_addr), 32'd160);
    end_line();
    check("ovr_line", 32'(line_cnt), 32'd1);
    check("ovr_pix_clr", 32'(pix_cnt), 32'd0);
    send_line(50, 1);
    check("short_addr", 32'(mem_addr), 32'd210);
    send_line(160, 1);
    check("after_short_addr", 32'(mem_addr), 32'd370);
    do_vsync();
    check("abort1_err", 32'(frame_err), 32'(mdl_err));
    check("abort1_addr", 32'(mem_addr), 32'd370);
    check("abort1_done", 32'(dut_done), 32'(mdl_done));

    // Abort after 40 complete lines
    do_inicio();
`ifndef CAPTURE_CONTINUOUS_EN
    check("err_clr_on_arm", 32'(frame_err), 32'd0);
`endif
    do_vsync();
    for (int l = 0; l < 40; l++) send_line(160, 1);
    do_vsync();
    check("abort40_err_lit", 32'(frame_err), 32'd1);
    check("abort40_addr", 32'(mem_addr), 32'd6400);
    check("abort40_done", 32'(dut_done), 32'(mdl_done));
    do_inicio();
    check("abort40_err_model", 32'(frame_err), 32'(mdl_err));
`ifndef CAPTURE_CONTINUOUS_EN
    check("abort40_err_clr", 32'(frame_err), 32'd0);
`endif

    // Reset mid-capture with inicio held and a pixel sampled on the reset edge
    inicio = 1'b1;
    do_vsync();
    for (int l = 0; l < 10; l++) send_line(160, 1);
    href = 1'b1;
    tick();
    px_valid = 1'b1;
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0; px_valid = 1'b0; inicio = 1'b0; href = 1'b0;
    mdl_idle = 1'b1; mdl_armed = 1'b0; mdl_active = 1'b0; mdl_err = 1'b0;
    exp_q.delete();
    check("rst_mid_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_pix", 32'(pix_cnt), 32'd0);
    check("rst_mid_line", 32'(line_cnt), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_err", 32'(frame_err), 32'd0);
    repeat (3) tick();
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("rst_mid_no_done", 32'(dut_done), 32'(mdl_done));
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): H_PIX, 160, pixels stored per line.
REQ-002 V_LINES, 96, lines stored per frame; frame size H_PIX*V_LINES = 15360.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- pclk, in, 1: camera pixel clock, the only clock.
- in_reset, in, 1: reset; one clock; reset is synchronous and active-high.
- inicio, in, 1: start request, level or pulse.
- vsync, in, 1: camera frame sync, high = vertical blank.
- href, in, 1: camera line valid.
- px_valid, in, 1: one-cycle strobe from the byte-pair converter, one complete pixel.
- mem_addr, out, 15: framebuffer write address.
- mem_wr, out, 1: framebuffer write strobe.
- pix_cnt, out, 8: pixel index within the current line.
- line_cnt, out, 7: current line index.
- busy, out, 1: high in ARM, SYNC and CAPTURE.
- done, out, 1: one-cycle frame-complete pulse.
- frame_err, out, 1: sticky short-frame flag.

Function
REQ-004 The FSM SHALL have states IDLE, ARM, SYNC, CAPTURE and DONE.
REQ-005 The FSM SHALL go IDLE->ARM on any pclk edge that samples inicio=1; inicio SHALL be ignored in every other state.
REQ-006 The FSM SHALL go ARM->SYNC on sampling vsync=1, and SYNC->CAPTURE on sampling vsync=0, so capture always starts on a full frame.
REQ-007 On entry to CAPTURE, mem_addr, pix_cnt and line_cnt SHALL be 0.
REQ-008 In CAPTURE, an edge sampling href=1, px_valid=1 and pix_cnt<H_PIX SHALL produce mem_wr=1 for exactly the next cycle, with mem_addr equal to the write address; mem_addr and pix_cnt SHALL then increment. Latency is 1 cycle.
REQ-009 Pixels with pix_cnt>=H_PIX SHALL be dropped: no mem_wr, no address change.
REQ-010 A line end is href_d=1 with href=0, where href_d is href registered on pclk.
- At a line end with pix_cnt>0: pix_cnt SHALL clear and line_cnt SHALL increment.
- At a line end with pix_cnt=0: no change.
REQ-011 Lines shorter than H_PIX SHALL NOT be padded; mem_addr SHALL continue from its current value.
REQ-012 The FSM SHALL go CAPTURE->DONE when mem_addr reaches H_PIX*V_LINES (the write at address 15359 is the last), or when line_cnt reaches V_LINES.
REQ-013 Sampling vsync=1 in CAPTURE before either REQ-012 condition is met SHALL set frame_err=1 and go to DONE.
REQ-014 If px_valid and vsync=1 are sampled in the same cycle, the vsync abort SHALL win and no write SHALL occur.
REQ-015 DONE SHALL last exactly one cycle with done=1, then leave DONE as set by REQ-020.
REQ-016 frame_err SHALL clear only on reset or on the IDLE->ARM transition.
REQ-017 mem_wr SHALL never be high outside the cycle following a CAPTURE-state sample.

Reset
REQ-018 Reset SHALL take priority over all other inputs. At a pclk edge with in_reset=1:
- state=IDLE and href_d=0.
- mem_addr=0, pix_cnt=0, line_cnt=0.
- mem_wr=0, busy=0, done=0, frame_err=0.
REQ-019 Reset asserted mid-CAPTURE SHALL suppress any pending mem_wr on the next cycle; the aborted frame SHALL NOT assert done.

Configuration
REQ-020 Macro CAPTURE_CONTINUOUS_EN SHALL select the DONE exit:
- Defined: DONE->ARM automatically, so every frame is captured without inicio.
- Undefined: DONE->IDLE; each frame needs a new inicio.

Verification
REQ-021 Reset, inicio=1, vsync pulse, then 96 lines of 160 px_valid strobes -> 15360 mem_wr pulses at addresses 0..15359, done=1 for one cycle, frame_err=0.
REQ-022 A line of 170 px_valid strobes -> 160 writes for that line, pix_cnt holds at 160, next line starts at mem_addr=160*(line+1).
REQ-023 vsync=1 after 40 complete lines -> frame_err=1, done pulse, mem_addr=6400; frame_err clears on the next inicio.
REQ-024 inicio held high during CAPTURE, then in_reset=1 after line 10 -> no mem_wr the following cycle, all outputs 0, state IDLE, no done.
REQ-025 With CAPTURE_CONTINUOUS_EN defined, two consecutive frames -> two done pulses, busy=1 in between; undefined -> second frame not written until inicio.
